// File: rtl/vga_raster_engine_if.sv
// Bus between the raster engine and the index/palette/DAC chain.
// The master side is the engine. The slave side is the consumer.
interface vga_raster_engine_if #(
    parameter int AW = 19
);
    logic          iBUF_SEL;
    logic [AW-1:0] oADDR;
    logic          oBANK;
    logic [9:0]    oX;
    logic [9:0]    oY;
    logic          oACTIVE;
    logic          oFRAME_START;
    logic          oHS;
    logic          oVS;
    logic          oBLANK_n;

    modport master (
        input  iBUF_SEL,
        output oADDR, oBANK, oX, oY, oACTIVE, oFRAME_START, oHS, oVS, oBLANK_n
    );

    modport slave (
        output iBUF_SEL,
        input  oADDR, oBANK, oX, oY, oACTIVE, oFRAME_START, oHS, oVS, oBLANK_n
    );
endinterface

// File: rtl/vga_raster_engine.sv
// Programmable raster timing with scaled framebuffer addressing and a frame-latched bank.
// Syncs and blank are delayed to match the downstream lookup latency.
module vga_raster_engine #(
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int SCALE    = 1,
    parameter int PIPE_LAT = 2,
    parameter int AW       = 19
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST,
    vga_raster_engine_if.master  vga
);
    localparam int H_TOT       = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT       = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW          = $clog2(H_TOT);
    localparam int VW          = $clog2(V_TOT);
    localparam int SW          = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int LINE_CELLS  = H_ACT / SCALE;
    localparam int FRAME_CELLS = LINE_CELLS * (V_ACT / SCALE);

    localparam logic [AW-1:0] LINE_STEP  = AW'(LINE_CELLS);
    localparam logic [AW-1:0] BANK1_BASE = AW'(FRAME_CELLS);
    localparam logic          SYNC_ON    = (SYNC_POL != 0);
    localparam logic          SYNC_OFF   = ~SYNC_ON;
    localparam logic [2:0]    PIPE_IDLE  = {SYNC_OFF, SYNC_OFF, 1'b0};

    // run stays low through reset so (0,0) is presented on the first clock after release
    logic          run;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [SW-1:0] x_sub, y_sub;
    logic [9:0]    x_cell, y_cell;
    logic [AW-1:0] line_base;
    logic [AW-1:0] addr_hold;
    logic          bank_q;

    logic          h_last, v_last, h_act, v_act;
    logic          active, frame_start, bank;
    logic [AW-1:0] addr_cur;
    logic          hs_raw, vs_raw;
    logic [2:0]    sig_raw, sig_out;

    assign h_last      = (hcount == HW'(H_TOT - 1));
    assign v_last      = (vcount == VW'(V_TOT - 1));
    assign h_act       = (hcount < HW'(H_ACT));
    assign v_act       = (vcount < VW'(V_ACT));
    assign active      = run && h_act && v_act;
    assign frame_start = run && (hcount == '0) && (vcount == '0);

    // the bank request is honoured on the frame-start cycle itself, then frozen for the frame
    assign bank     = frame_start ? vga.iBUF_SEL : bank_q;
    assign addr_cur = (bank ? BANK1_BASE : '0) + line_base + AW'(x_cell);

    assign hs_raw = run && (hcount >= HW'(H_ACT + H_FP)) && (hcount < HW'(H_ACT + H_FP + H_SYNC));
    assign vs_raw = run && (vcount >= VW'(V_ACT + V_FP)) && (vcount < VW'(V_ACT + V_FP + V_SYNC));

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            run       <= 1'b0;
            hcount    <= '0;
            vcount    <= '0;
            x_sub     <= '0;
            y_sub     <= '0;
            x_cell    <= '0;
            y_cell    <= '0;
            line_base <= '0;
            addr_hold <= '0;
            bank_q    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                hcount <= h_last ? '0 : hcount + 1'b1;
                if (h_last)
                    vcount <= v_last ? '0 : vcount + 1'b1;

                if (h_last) begin
                    x_sub  <= '0;
                    x_cell <= '0;
                end else if (h_act) begin
                    if (x_sub == SW'(SCALE - 1)) begin
                        x_sub  <= '0;
                        x_cell <= x_cell + 1'b1;
                    end else begin
                        x_sub <= x_sub + 1'b1;
                    end
                end

                // line_base steps once per SCALE active lines, at the last active pixel
                if (h_last && v_last) begin
                    y_sub     <= '0;
                    y_cell    <= '0;
                    line_base <= '0;
                end else if ((hcount == HW'(H_ACT - 1)) && v_act) begin
                    if (y_sub == SW'(SCALE - 1)) begin
                        y_sub     <= '0;
                        y_cell    <= y_cell + 1'b1;
                        line_base <= line_base + LINE_STEP;
                    end else begin
                        y_sub <= y_sub + 1'b1;
                    end
                end

                if (frame_start)
                    bank_q <= vga.iBUF_SEL;
                if (active)
                    addr_hold <= addr_cur;
            end
        end
    end

    assign sig_raw = {hs_raw ? SYNC_ON : SYNC_OFF, vs_raw ? SYNC_ON : SYNC_OFF, active};

    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign sig_out = sig_raw;
        end else begin : g_dly
            logic [PIPE_LAT-1:0][2:0] sig_pipe;
            always_ff @(posedge iVGA_CLK) begin
                if (iRST) begin
                    for (int i = 0; i < PIPE_LAT; i++)
                        sig_pipe[i] <= PIPE_IDLE;
                end else begin
                    sig_pipe[0] <= sig_raw;
                    for (int i = 1; i < PIPE_LAT; i++)
                        sig_pipe[i] <= sig_pipe[i-1];
                end
            end
            assign sig_out = sig_pipe[PIPE_LAT-1];
        end
    endgenerate

    assign vga.oADDR        = active ? addr_cur : addr_hold;
    assign vga.oBANK        = bank;
    assign vga.oX           = active ? x_cell : 10'd0;
    assign vga.oY           = active ? y_cell : 10'd0;
    assign vga.oACTIVE      = active;
    assign vga.oFRAME_START = frame_start;
    assign vga.oHS          = sig_out[2];
    assign vga.oVS          = sig_out[1];
    assign vga.oBLANK_n     = sig_out[0];
endmodule

// File: tb/tb_vga_raster_engine.sv
// Directed bench: a default-timing engine plus three small-timing engines
// (scale 1/2/4, latency 2/0/5, both sync polarities) on one clock and reset.
module tb_vga_raster_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    int   p = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_raster_engine_if #(.AW(19)) if_def ();
    vga_raster_engine_if #(.AW(8))  if_sm ();
    vga_raster_engine_if #(.AW(8))  if_s2 ();
    vga_raster_engine_if #(.AW(8))  if_s4 ();

    assign if_def.iBUF_SEL = sel;
    assign if_sm.iBUF_SEL  = sel;
    assign if_s2.iBUF_SEL  = sel;
    assign if_s4.iBUF_SEL  = sel;

    vga_raster_engine u_def (.iVGA_CLK(clk), .iRST(rst), .vga(if_def));

    vga_raster_engine #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .SCALE(1), .PIPE_LAT(2), .AW(8)
    ) u_sm (.iVGA_CLK(clk), .iRST(rst), .vga(if_sm));

    vga_raster_engine #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .SCALE(2), .PIPE_LAT(0), .AW(8)
    ) u_s2 (.iVGA_CLK(clk), .iRST(rst), .vga(if_s2));

    vga_raster_engine #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .SCALE(4), .PIPE_LAT(5), .AW(8)
    ) u_s4 (.iVGA_CLK(clk), .iRST(rst), .vga(if_s4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d (p=%0d)", tag, obs, exp, p);
        end
    endtask

    // p = clocks since reset release minus one, i.e. the raster position index
    task automatic tick();
        @(posedge clk);
        #1;
        p++;
    endtask

    task automatic goto(input int t);
        while (p < t) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst def addr",  32'(if_def.oADDR), 0);
        chk("rst def act",   32'(if_def.oACTIVE), 0);
        chk("rst def fs",    32'(if_def.oFRAME_START), 0);
        chk("rst def blank", 32'(if_def.oBLANK_n), 0);
        chk("rst def hs",    32'(if_def.oHS), 1);
        chk("rst def vs",    32'(if_def.oVS), 1);
        chk("rst def bank",  32'(if_def.oBANK), 0);
        chk("rst sm hs",     32'(if_sm.oHS), 0);
        chk("rst sm vs",     32'(if_sm.oVS), 0);
        chk("rst s2 x",      32'(if_s2.oX), 0);

        rst = 1'b0;
        p = -1;
        tick();
        chk("p0 def fs",    32'(if_def.oFRAME_START), 1);
        chk("p0 def act",   32'(if_def.oACTIVE), 1);
        chk("p0 def addr",  32'(if_def.oADDR), 0);
        chk("p0 def blank", 32'(if_def.oBLANK_n), 0);
        chk("p0 def hs",    32'(if_def.oHS), 1);
        chk("p0 s2 blank",  32'(if_s2.oBLANK_n), 1);
        chk("p0 s2 fs",     32'(if_s2.oFRAME_START), 1);
        chk("p0 s4 blank",  32'(if_s4.oBLANK_n), 0);
        chk("p0 sm addr",   32'(if_sm.oADDR), 0);
        goto(1);
        chk("p1 def fs",   32'(if_def.oFRAME_START), 0);
        chk("p1 def addr", 32'(if_def.oADDR), 1);
        chk("p1 s2 addr",  32'(if_s2.oADDR), 0);
        goto(2);
        chk("p2 def blank", 32'(if_def.oBLANK_n), 1);
        chk("p2 s2 addr",   32'(if_s2.oADDR), 1);
        chk("p2 s2 x",      32'(if_s2.oX), 1);
        chk("p2 s4 addr",   32'(if_s4.oADDR), 0);
        goto(4);
        chk("p4 s4 blank", 32'(if_s4.oBLANK_n), 0);
        chk("p4 s4 addr",  32'(if_s4.oADDR), 1);
        goto(5);
        chk("p5 s4 blank", 32'(if_s4.oBLANK_n), 1);
        goto(7);
        chk("p7 sm addr", 32'(if_sm.oADDR), 7);
        chk("p7 sm x",    32'(if_sm.oX), 7);
        goto(8);
        chk("p8 sm act",  32'(if_sm.oACTIVE), 0);
        chk("p8 sm hold", 32'(if_sm.oADDR), 7);
        chk("p8 sm x",    32'(if_sm.oX), 0);
        goto(11); chk("sm hs pre",   32'(if_sm.oHS), 0);
        goto(12); chk("sm hs rise",  32'(if_sm.oHS), 1);
        goto(14); chk("sm hs last",  32'(if_sm.oHS), 1);
        goto(15); chk("sm hs fall",  32'(if_sm.oHS), 0);
        goto(16);
        chk("sm line1 addr", 32'(if_sm.oADDR), 8);
        chk("sm line1 y",    32'(if_sm.oY), 1);
        chk("s2 line1 addr", 32'(if_s2.oADDR), 0);
        chk("s2 line1 y",    32'(if_s2.oY), 0);
        goto(32);
        chk("s2 line2 addr", 32'(if_s2.oADDR), 4);
        chk("s2 line2 y",    32'(if_s2.oY), 1);
        goto(64);
        chk("s4 line4 addr", 32'(if_s4.oADDR), 2);
        chk("s4 line4 y",    32'(if_s4.oY), 1);
        goto(119);
        chk("s4 last addr", 32'(if_s4.oADDR), 3);

        goto(657); chk("def hs pre",  32'(if_def.oHS), 1);
        goto(658); chk("def hs fall", 32'(if_def.oHS), 0);
        goto(753); chk("def hs last", 32'(if_def.oHS), 0);
        goto(754); chk("def hs rise", 32'(if_def.oHS), 1);
        goto(799);
        chk("def eol act",  32'(if_def.oACTIVE), 0);
        chk("def eol hold", 32'(if_def.oADDR), 639);
        goto(800);
        chk("def line1 act",  32'(if_def.oACTIVE), 1);
        chk("def line1 addr", 32'(if_def.oADDR), 640);
        chk("def line1 y",    32'(if_def.oY), 1);
        chk("def line1 x",    32'(if_def.oX), 0);
        chk("sm f5 fs",       32'(if_sm.oFRAME_START), 1);
        chk("sm f5 addr",     32'(if_sm.oADDR), 0);

        goto(887);
        chk("sm last addr", 32'(if_sm.oADDR), 47);
        chk("s2 last addr", 32'(if_s2.oADDR), 11);
        goto(888);
        chk("sm post hold", 32'(if_sm.oADDR), 47);
        chk("sm post act",  32'(if_sm.oACTIVE), 0);
        goto(913); chk("sm vs pre",  32'(if_sm.oVS), 0);
        goto(914); chk("sm vs rise", 32'(if_sm.oVS), 1);
        goto(945); chk("sm vs last", 32'(if_sm.oVS), 1);
        goto(946); chk("sm vs fall", 32'(if_sm.oVS), 0);
        goto(959); chk("sm f5 end fs", 32'(if_sm.oFRAME_START), 0);
        goto(960);
        chk("sm f6 fs",   32'(if_sm.oFRAME_START), 1);
        chk("sm f6 addr", 32'(if_sm.oADDR), 0);

        goto(1010);
        sel = 1'b1;
        goto(1024);
        chk("bank hold0",  32'(if_sm.oBANK), 0);
        chk("bank0 addr",  32'(if_sm.oADDR), 32);
        goto(1119);
        chk("bank end0",   32'(if_sm.oBANK), 0);
        goto(1120);
        chk("bank swap1",  32'(if_sm.oBANK), 1);
        chk("bank1 base",  32'(if_sm.oADDR), 48);
        chk("bank1 fs",    32'(if_sm.oFRAME_START), 1);
        chk("s2 bank1 base", 32'(if_s2.oADDR), 12);
        goto(1121);
        chk("bank1 addr1", 32'(if_sm.oADDR), 49);
        chk("bank1 kept",  32'(if_sm.oBANK), 1);
        goto(1150);
        sel = 1'b0;
        goto(1279);
        chk("bank end1",   32'(if_sm.oBANK), 1);
        chk("bank1 hold",  32'(if_sm.oADDR), 95);
        goto(1280);
        chk("bank swap0",  32'(if_sm.oBANK), 0);
        chk("bank0 base",  32'(if_sm.oADDR), 0);

        goto(1333);
        chk("pre rst sm addr", 32'(if_sm.oADDR), 29);
        rst = 1'b1;
        tick();
        chk("mid rst sm hs",    32'(if_sm.oHS), 0);
        chk("mid rst sm vs",    32'(if_sm.oVS), 0);
        chk("mid rst sm blank", 32'(if_sm.oBLANK_n), 0);
        chk("mid rst sm act",   32'(if_sm.oACTIVE), 0);
        chk("mid rst sm addr",  32'(if_sm.oADDR), 0);
        chk("mid rst def hs",   32'(if_def.oHS), 1);
        chk("mid rst def vs",   32'(if_def.oVS), 1);
        chk("mid rst def blank", 32'(if_def.oBLANK_n), 0);
        chk("mid rst def addr", 32'(if_def.oADDR), 0);
        chk("mid rst s4 y",     32'(if_s4.oY), 0);
        rst = 1'b0;
        p = -1;
        tick();
        chk("restart sm fs",    32'(if_sm.oFRAME_START), 1);
        chk("restart sm addr",  32'(if_sm.oADDR), 0);
        chk("restart sm act",   32'(if_sm.oACTIVE), 1);
        chk("restart sm blank", 32'(if_sm.oBLANK_n), 0);
        chk("restart def fs",   32'(if_def.oFRAME_START), 1);
        chk("restart def addr", 32'(if_def.oADDR), 0);
        goto(2);
        chk("restart sm blank2", 32'(if_sm.oBLANK_n), 1);
        goto(3);
        chk("restart sm addr3",  32'(if_sm.oADDR), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
